// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial add/subtract sequencer.
// One full-adder cell is walked across two latched 8-bit operands,
// LSB first, one bit per clock. The running carry lives in a flop and
// bit_sel drives the 8:1 operand mux selects outside this block.
//
// Handshake: a start is accepted only on a clock edge where the FSM is
// in IDLE and clear is low; start at any other time is dropped (never
// queued). busy is high in RUN and DONE, and done is a one-cycle pulse
// in DONE. sum/cout/ovf are valid from the edge that enters DONE and
// are held until the next accepted start. clear beats start.
module serial_add_seq #(
  parameter int WIDTH = 8,
  parameter int SELW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [SELW-1:0]  bit_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [SELW-1:0] LAST_BIT = SELW'(WIDTH - 1);
  localparam logic [SELW-1:0] SIGN_IN  = SELW'(WIDTH - 2);

  state_e           state_q, state_d;
  logic [SELW-1:0]  bit_sel_q, bit_sel_d;
  logic             carry_q, carry_d;
  logic             c7in_q, c7in_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_a, fa_b, fa_s, fa_c;

  // Single full-adder cell fed by the currently selected operand bits.
  always_comb begin
    fa_a = op_a_q[bit_sel_q];
    fa_b = op_b_q[bit_sel_q];
    fa_s = fa_a ^ fa_b ^ carry_q;
    fa_c = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);
  end

  // Next-state and datapath update; clear overrides everything else.
  always_comb begin
    state_d   = state_q;
    bit_sel_d = bit_sel_q;
    carry_d   = carry_q;
    c7in_d    = c7in_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    if (clear) begin
      state_d   = S_IDLE;
      bit_sel_d = '0;
      carry_d   = 1'b0;
      c7in_d    = 1'b0;
      sum_d     = '0;
      cout_d    = 1'b0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1, so the inverted operand and a forced
            // carry-in of 1 are set up here; cin is ignored for subtract.
            op_a_d    = a;
            op_b_d    = sub ? ~b : b;
            carry_d   = sub ? 1'b1 : cin;
            sum_d     = '0;
            bit_sel_d = '0;
            state_d   = S_RUN;
          end
        end
        S_RUN: begin
          sum_d[bit_sel_q] = fa_s;
          carry_d          = fa_c;
          if (bit_sel_q == SIGN_IN) begin
            c7in_d = fa_c;
          end
          if (bit_sel_q == LAST_BIT) begin
            cout_d  = fa_c;
            ovf_d   = c7in_q ^ fa_c;
            state_d = S_DONE;
          end else begin
            bit_sel_d = bit_sel_q + SELW'(1);
          end
        end
        S_DONE: begin
          bit_sel_d = '0;
          state_d   = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_sel_q <= '0;
      carry_q   <= 1'b0;
      c7in_q    <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_sel_q <= bit_sel_d;
      carry_q   <= carry_d;
      c7in_q    <= c7in_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bit_sel   = bit_sel_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule
